fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that succeeds the single-register program counter plus instruction memory pairing. It owns the PC, issues one read per cycle to a fixed-latency instruction memory, and buffers the returned words with their PCs in a prefetch FIFO. It delivers them to decode over a valid/ready handshake. A redirect (branch or jump) flushes the FIFO, discards in-flight reads and restarts fetch at a new PC.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: address/instruction words and the fetch entry.
package cpu_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int INSTR_BYTES = 4;

  typedef logic [ADDR_W_DEF-1:0]  addr_t;
  typedef logic [INSTR_W_DEF-1:0] instr_t;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of entry_t, head presented from the storage
// flops, flush wins over push. Head reads as zero while the FIFO is empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output logic                   head_valid,
  output entry_t                 head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               push_ok;
  logic               pop_ok;

  assign push_ok    = push & (cnt_q != CNT_W'(DEPTH));
  assign pop_ok     = pop & (cnt_q != '0);
  assign head_valid = (cnt_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = cnt_q;

  // Control stage: pointers and occupancy; flush empties in one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Data stage: entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one read per cycle to a
// 1-cycle-latency instruction memory, buffers responses in fetch_fifo and
// hands them to decode over valid/ready. Redirect flushes and restarts.
// Optional FETCH_PERF_EN adds delivered-instruction and redirect counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_redirect_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              inflight_q;
  logic              drop_q;
  logic              fifo_valid;
  entry_t            head;
  entry_t            push_entry;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W:0]    demand;
  logic              pop;
  logic              push;
  logic              unused_pc_lsbs;

  // Low address bits of a redirect target are forced to zero.
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign instr_valid = fifo_valid & ~redirect_valid;
  assign pop         = instr_valid & instr_ready;
  // Slots that will be taken once the in-flight read lands, net of this pop.
  assign demand      = {1'b0, occ} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign imem_req    = ~reset & ~redirect_valid & (demand < (CNT_W+1)'(DEPTH));
  assign imem_addr   = pc_q;
  assign push        = imem_rvalid & inflight_q & ~drop_q & ~redirect_valid;
  assign push_entry  = '{pc: req_pc_q, instr: imem_rdata};
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  // Request stage: PC advance, in-flight tracking and redirect restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_pc[ADDR_W-1:2], 2'b00};
      inflight_q <= 1'b0;
      drop_q     <= inflight_q;
    end else begin
      inflight_q <= imem_req;
      drop_q     <= 1'b0;
      if (imem_req) pc_q <= pc_q + ADDR_W'(INSTR_BYTES);
    end
  end

  // Request-to-response stage: PC that travels with the outstanding read.
  always_ff @(posedge clk) begin
    if (imem_req) req_pc_q <= pc_q;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head_valid (fifo_valid),
    .head_data  (head),
    .count      (occ)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] redirect_cnt_q;

  // Perf stage: wrapping counts of delivered instructions and redirects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (pop)            fetch_cnt_q    <= fetch_cnt_q + 32'd1;
      if (redirect_valid) redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
`else
  assign perf_fetch_cnt    = 32'd0;
  assign perf_redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/backpressure, redirects,
// PC wrap, asynchronous reset and the optional perf counters.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stray = 1'b0;
  logic        imem_req, instr_valid, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc;
  logic [31:0] perf_fetch_cnt, perf_redirect_cnt;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  logic        w_rst = 1'b1;
  logic        w_ready = 1'b1;
  logic        w_req, w_instr_valid;
  logic [31:0] w_addr, w_instr, w_instr_pc, w_pf, w_pr;
  logic        w_mem_rvalid = 1'b0;
  logic [31:0] w_mem_rdata = 32'd0;

  int total = 0;
  int bad = 0;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  // Memory models: word returned equals its address, one cycle after request.
  always @(posedge clk) begin
    mem_rvalid   <= imem_req;
    mem_rdata    <= imem_addr;
    w_mem_rvalid <= w_req;
    w_mem_rdata  <= w_addr;
  end
  assign imem_rvalid = mem_rvalid | stray;
  assign imem_rdata  = mem_rvalid ? mem_rdata : 32'hDEADBEEF;

  fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
    .clk(clk), .reset(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .perf_fetch_cnt(perf_fetch_cnt),
    .perf_redirect_cnt(perf_redirect_cnt)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(w_rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_mem_rvalid), .imem_rdata(w_mem_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .instr_valid(w_instr_valid), .instr_ready(w_ready), .instr(w_instr),
    .instr_pc(w_instr_pc), .perf_fetch_cnt(w_pf), .perf_redirect_cnt(w_pr)
  );

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; stray = 1'b0;
    @(negedge clk);
  endtask

  task automatic start(input logic rdy);
    @(negedge clk);
    rst = 1'b0; instr_ready = rdy; redirect_valid = 1'b0; redirect_pc = 32'd0;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL rst_addr got=%h exp=00000100", imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    total++; if (instr !== 32'd0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
    total++; if (instr_pc !== 32'd0) begin bad++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    total++; if (perf_fetch_cnt !== 32'd0) begin bad++; $display("FAIL rst_perf_fetch got=%0d exp=0", perf_fetch_cnt); end
    total++; if (perf_redirect_cnt !== 32'd0) begin bad++; $display("FAIL rst_perf_redir got=%0d exp=0", perf_redirect_cnt); end
    total++; if (w_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rst_wrap_addr got=%h exp=fffffffc", w_addr); end
  endtask

  task automatic test_stream();
    start(1'b1);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL stream_c0 req=%b addr=%h exp 1/00000100", imem_req, imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_c0_valid got=%b exp=0", instr_valid); end
    cyc(1'b1, 1'b0, 32'd0);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin bad++; $display("FAIL stream_c1 req=%b addr=%h exp 1/00000104", imem_req, imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_c1_valid got=%b exp=0", instr_valid); end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 32'd0);
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 + 4*k || instr !== 32'h100 + 4*k) begin
        bad++; $display("FAIL stream_out k=%0d valid=%b pc=%h instr=%h exp pc/instr=%h", k, instr_valid, instr_pc, instr, 32'h100 + 4*k); end
      total++; if (imem_addr !== 32'h108 + 4*k) begin bad++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, imem_addr, 32'h108 + 4*k); end
    end
  endtask

  task automatic test_stall();
    hold_reset();
    start(1'b0);
    for (int c = 1; c < 10; c++) begin
      cyc(1'b0, 1'b0, 32'd0);
      total++; if (imem_req !== (c < 4)) begin bad++; $display("FAIL stall_req c%0d got=%b exp=%b", c, imem_req, (c < 4)); end
      total++; if (instr_valid !== (c >= 2)) begin bad++; $display("FAIL stall_valid c%0d got=%b exp=%b", c, instr_valid, (c >= 2)); end
      if (c >= 2) begin
        total++; if (instr_pc !== 32'h100) begin bad++; $display("FAIL stall_head c%0d got=%h exp=00000100", c, instr_pc); end
      end
    end
    for (int c = 10; c < 17; c++) begin
      cyc(1'b1, 1'b0, 32'd0);
      if (c == 10) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin bad++; $display("FAIL release_req req=%b addr=%h exp 1/00000110", imem_req, imem_addr); end
      end
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 + 4*(c-10) || instr !== 32'h100 + 4*(c-10)) begin
        bad++; $display("FAIL release_out c%0d valid=%b pc=%h instr=%h exp=%h", c, instr_valid, instr_pc, instr, 32'h100 + 4*(c-10)); end
    end
  endtask

  task automatic test_redirect();
    hold_reset();
    start(1'b0);
    repeat (3) cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 32'h2000);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", instr_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_req got=%b exp=0", imem_req); end
    cyc(1'b1, 1'b0, 32'd0);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin bad++; $display("FAIL redir_t1 req=%b addr=%h exp 1/00002000", imem_req, imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_t1_valid got=%b exp=0", instr_valid); end
    cyc(1'b1, 1'b0, 32'd0);
    total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h2004) begin bad++; $display("FAIL redir_t2 valid=%b addr=%h exp 0/00002004", instr_valid, imem_addr); end
    cyc(1'b1, 1'b0, 32'd0);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h2000 || instr !== 32'h2000) begin bad++; $display("FAIL redir_t3 valid=%b pc=%h instr=%h exp 1/00002000", instr_valid, instr_pc, instr); end
    cyc(1'b1, 1'b0, 32'd0);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h2004) begin bad++; $display("FAIL redir_t4 valid=%b pc=%h exp 1/00002004", instr_valid, instr_pc); end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b1, 32'h3000);
    total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL b2b_first valid=%b req=%b exp 0/0", instr_valid, imem_req); end
    cyc(1'b1, 1'b1, 32'h2003);
    total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL b2b_second valid=%b req=%b exp 0/0", instr_valid, imem_req); end
    cyc(1'b1, 1'b0, 32'd0);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin bad++; $display("FAIL b2b_align req=%b addr=%h exp 1/00002000", imem_req, imem_addr); end
    cyc(1'b1, 1'b0, 32'd0);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0", instr_valid); end
    cyc(1'b1, 1'b0, 32'd0);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h2000) begin bad++; $display("FAIL b2b_out0 valid=%b pc=%h exp 1/00002000", instr_valid, instr_pc); end
    cyc(1'b1, 1'b0, 32'd0);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h2004) begin bad++; $display("FAIL b2b_out1 valid=%b pc=%h exp 1/00002004", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap();
    @(negedge clk); w_rst = 1'b0; w_ready = 1'b1; #1;
    total++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_c0 req=%b addr=%h exp 1/fffffffc", w_req, w_addr); end
    @(negedge clk); #1;
    total++; if (w_addr !== 32'h0) begin bad++; $display("FAIL wrap_c1_addr got=%h exp=00000000", w_addr); end
    @(negedge clk); #1;
    total++; if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC || w_instr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_out0 valid=%b pc=%h instr=%h exp fffffffc", w_instr_valid, w_instr_pc, w_instr); end
    @(negedge clk); #1;
    total++; if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'h0 || w_instr !== 32'h0) begin bad++; $display("FAIL wrap_out1 valid=%b pc=%h instr=%h exp 00000000", w_instr_valid, w_instr_pc, w_instr); end
  endtask

  task automatic test_async_reset();
    hold_reset();
    start(1'b1);
    repeat (4) cyc(1'b1, 1'b0, 32'd0);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h108) begin bad++; $display("FAIL areset_pre valid=%b pc=%h exp 1/00000108", instr_valid, instr_pc); end
    #2; rst = 1'b1; #1;
    total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL areset_now valid=%b req=%b exp 0/0", instr_valid, imem_req); end
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL areset_addr got=%h exp=00000100", imem_addr); end
    @(negedge clk); rst = 1'b0; stray = 1'b1; instr_ready = 1'b1; #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL areset_restart req=%b addr=%h exp 1/00000100", imem_req, imem_addr); end
    @(negedge clk); stray = 1'b0; #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL areset_stray valid=%b exp=0", instr_valid); end
    @(negedge clk); #1;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h100) begin bad++; $display("FAIL areset_first valid=%b pc=%h instr=%h exp 1/00000100", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_perf();
    hold_reset();
    start(1'b1);
    cyc(1'b1, 1'b0, 32'd0);
    total++; if (perf_fetch_cnt !== 32'd0) begin bad++; $display("FAIL perf_c1 got=%0d exp=0", perf_fetch_cnt); end
    for (int c = 2; c < 12; c++) begin
      cyc(1'b1, 1'b0, 32'd0);
      if (c == 7) begin
        total++; if (perf_fetch_cnt !== (PERF ? 32'd5 : 32'd0)) begin bad++; $display("FAIL perf_mid got=%0d exp=%0d", perf_fetch_cnt, PERF ? 5 : 0); end
      end
    end
    cyc(1'b0, 1'b1, 32'h40);
    cyc(1'b0, 1'b1, 32'h80);
    cyc(1'b0, 1'b0, 32'd0);
    total++; if (perf_fetch_cnt !== (PERF ? 32'd10 : 32'd0)) begin bad++; $display("FAIL perf_fetch got=%0d exp=%0d", perf_fetch_cnt, PERF ? 10 : 0); end
    total++; if (perf_redirect_cnt !== (PERF ? 32'd2 : 32'd0)) begin bad++; $display("FAIL perf_redirect got=%0d exp=%0d", perf_redirect_cnt, PERF ? 2 : 0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
